// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the unified memory arbiter.
// Owner codes tag which pipeline stage a bus access belongs to.
package mips_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } uma_state_e;
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: pipeline-side IF/MEM requests and memory-side req/ready bus.
// master is the arbiter's view; slave is the pipeline plus memory model.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              dm_stall;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;
    logic              bus_err;
    modport master (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, bus_rdata, bus_ready,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
    modport slave (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, bus_rdata, bus_ready,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between IF fetches and MEM loads/stores.
// Define UMA_TIMEOUT_EN to add the BUSY timeout counter and sticky bus_err.
module unified_mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef UMA_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.master mb
);
    uma_state_e        r_state, w_next;
    logic              r_owner, r_drop, w_busy, w_timeout, w_done;
    logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
    logic [ADDR_W-1:0] w_addr;

    assign w_busy = (r_state == BUSY_IF) || (r_state == BUSY_DM);
    assign w_done = mb.bus_ready || w_timeout;

    // MEM wins ties: it holds the older instruction.
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = mb.dm_req ? BUSY_DM : (mb.if_req && !mb.if_flush) ? BUSY_IF : IDLE;
        else if (r_state == RESP)
            w_next = IDLE;
        else if (w_done)
            w_next = RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= OWNER_IF;
            r_drop     <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) r_owner <= mb.dm_req ? OWNER_DM : OWNER_IF;
            r_drop <= (r_state == RESP) ? 1'b0 : r_drop | ((r_state == BUSY_IF) && mb.if_flush);
            if ((r_state == BUSY_IF) && w_done) r_if_rdata <= mb.bus_ready ? mb.bus_rdata : '0;
            if ((r_state == BUSY_DM) && w_done) r_dm_rdata <= mb.bus_ready ? mb.bus_rdata : '0;
        end
    end

    assign w_addr       = (r_state == BUSY_DM) ? mb.dm_addr : (r_state == BUSY_IF) ? mb.if_addr : '0;
    assign mb.bus_addr  = w_addr;
    assign mb.bus_req   = w_busy;
    assign mb.bus_we    = (r_state == BUSY_DM) && mb.dm_we;
    assign mb.bus_wdata = (r_state == BUSY_DM) ? mb.dm_wdata : '0;
    // A flush seen during the access or in the response cycle swallows the fetch result.
    assign mb.if_done   = (r_state == RESP) && (r_owner == OWNER_IF) && !r_drop && !mb.if_flush;
    assign mb.dm_done   = (r_state == RESP) && (r_owner == OWNER_DM);
    assign mb.if_rdata  = r_if_rdata;
    assign mb.dm_rdata  = r_dm_rdata;
    assign mb.if_stall  = mb.if_req && !mb.if_done && !rst;
    assign mb.dm_stall  = mb.dm_req && !mb.dm_done && !rst;

`ifdef UMA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tcnt;
    logic          r_err;
    assign w_timeout = w_busy && !mb.bus_ready && (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= !w_busy ? '0 : mb.bus_ready ? r_tcnt : r_tcnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
        end
    end
    assign mb.bus_err = r_err;
`else
    assign w_timeout  = 1'b0;
    assign mb.bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed stimulus with a scoreboard of expected completions.
// Honours UMA_TIMEOUT_EN (timeout scenario) when the macro is defined.
module tb_unified_mem_arbiter;
    logic clk, rst;
    int   cyc, n_pass, n_total, mem_wait, t_if, t_dm, t_rdy, t0;
    logic [31:0] mem [logic [31:0]];
    typedef struct { logic dm; logic [31:0] data; } exp_t;
    exp_t sb [$];

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u ();

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32)
`ifdef UMA_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (.clk(clk), .rst(rst), .mb(u));

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial begin cyc = 0; forever begin @(posedge clk); cyc++; end end
    initial begin #200000; $display("FAIL watchdog expired"); $fatal(1); end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic wait_dm(input int lim);
        for (int i = 0; i < lim; i++) begin @(negedge clk); if (u.dm_done) return; end
        chk("dm_done_wait", 0, 1);
    endtask

    task automatic wait_if(input int lim);
        for (int i = 0; i < lim; i++) begin @(negedge clk); if (u.if_done) return; end
        chk("if_done_wait", 0, 1);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    // Memory model: bus_ready after mem_wait extra BUSY cycles, stores land on ready.
    initial begin
        int cnt;
        cnt = 0; u.bus_ready = 0; u.bus_rdata = 0;
        forever begin
            @(negedge clk);
            if (u.bus_req) begin
                u.bus_ready = (cnt == mem_wait);
                u.bus_rdata = mem.exists(u.bus_addr) ? mem[u.bus_addr] : 32'h0;
                if (u.bus_ready) begin
                    t_rdy = cyc;
                    if (u.bus_we) mem[u.bus_addr] = u.bus_wdata;
                end
                cnt++;
            end else begin
                u.bus_ready = 0; cnt = 0;
            end
        end
    end

    // Monitor: every completion pulse must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (u.if_done || u.dm_done)) begin
                if (sb.size() == 0) chk("unexpected_done", {30'd0, u.if_done, u.dm_done}, 0);
                else begin
                    e = sb.pop_front();
                    chk("done_owner", {31'd0, u.dm_done}, {31'd0, e.dm});
                    chk("done_excl", {31'd0, u.if_done}, {31'd0, !e.dm});
                    if (e.dm) chk("dm_rdata", u.dm_rdata, e.data);
                    else      chk("if_rdata", u.if_rdata, e.data);
                end
                if (u.dm_done) t_dm = cyc;
                if (u.if_done) t_if = cyc;
            end
        end
    end

    initial begin
        n_pass = 0; n_total = 0; mem_wait = 0; t_if = 0; t_dm = 0; t_rdy = 0;
        mem[32'h0040_0000] = 32'h2008_0005;
        mem[32'h0040_0004] = 32'h8C08_0000;
        mem[32'h0040_0010] = 32'h1111_1111;
        mem[32'h0040_0020] = 32'h2402_0001;
        rst = 1;
        u.if_req = 1; u.if_addr = 32'h0040_0000; u.if_flush = 0;
        u.dm_req = 0; u.dm_we = 0; u.dm_addr = 0; u.dm_wdata = 0;
        // Reset held two cycles with a pending fetch
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", {31'd0, u.bus_req}, 0);
        chk("rst_bus_addr", u.bus_addr, 0);
        chk("rst_bus_we", {31'd0, u.bus_we}, 0);
        chk("rst_if_stall", {31'd0, u.if_stall}, 0);
        chk("rst_dm_stall", {31'd0, u.dm_stall}, 0);
        chk("rst_if_done", {31'd0, u.if_done}, 0);
        chk("rst_if_rdata", u.if_rdata, 0);
        chk("rst_dm_rdata", u.dm_rdata, 0);
        chk("rst_bus_err", {31'd0, u.bus_err}, 0);
        // Single fetch, zero-wait memory
        step; rst = 0; t0 = cyc;
        sb.push_back('{1'b0, 32'h2008_0005});
        @(negedge clk);
        chk("c0_bus_req", {31'd0, u.bus_req}, 0);
        chk("c0_if_stall", {31'd0, u.if_stall}, 1);
        @(negedge clk);
        chk("c1_bus_req", {31'd0, u.bus_req}, 1);
        chk("c1_bus_addr", u.bus_addr, 32'h0040_0000);
        chk("c1_bus_we", {31'd0, u.bus_we}, 0);
        chk("c1_if_stall", {31'd0, u.if_stall}, 1);
        @(negedge clk);
        chk("c2_if_stall", {31'd0, u.if_stall}, 0);
        step; u.if_req = 0;
        chk("fetch_latency", t_if - t0, 2);
        // Contention: store first, fetch three cycles later
        u.if_req = 1; u.if_addr = 32'h0040_0004;
        u.dm_req = 1; u.dm_we = 1; u.dm_addr = 32'h1001_0000; u.dm_wdata = 32'hCAFE_F00D;
        sb.push_back('{1'b1, 32'h0});
        sb.push_back('{1'b0, 32'h8C08_0000});
        @(negedge clk); @(negedge clk);
        chk("st_bus_we", {31'd0, u.bus_we}, 1);
        chk("st_bus_addr", u.bus_addr, 32'h1001_0000);
        chk("st_bus_wdata", u.bus_wdata, 32'hCAFE_F00D);
        chk("st_if_stall", {31'd0, u.if_stall}, 1);
        wait_dm(10);
        step; u.dm_req = 0; u.dm_we = 0;
        @(negedge clk);
        chk("wait_if_stall", {31'd0, u.if_stall}, 1);
        wait_if(10);
        step; u.if_req = 0;
        chk("dm_to_if_gap", t_if - t_dm, 3);
        chk("store_landed", mem[32'h1001_0000], 32'hCAFE_F00D);
        // Load with four wait states
        u.dm_req = 1; u.dm_addr = 32'h1001_0000; mem_wait = 4;
        sb.push_back('{1'b1, 32'hCAFE_F00D});
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ws_bus_req", {31'd0, u.bus_req}, 1);
            chk("ws_bus_addr", u.bus_addr, 32'h1001_0000);
            chk("ws_bus_we", {31'd0, u.bus_we}, 0);
            chk("ws_dm_done", {31'd0, u.dm_done}, 0);
        end
        wait_dm(3);
        chk("ready_to_done", t_dm - t_rdy, 1);
        step; u.dm_req = 0; mem_wait = 2;
        // Fetch flushed in its second BUSY cycle
        u.if_req = 1; u.if_addr = 32'h0040_0010;
        step; step; u.if_flush = 1;
        step; u.if_flush = 0;
        @(negedge clk); @(negedge clk);
        chk("flush_no_done", {31'd0, u.if_done}, 0);
        chk("flush_resp_stall", {31'd0, u.if_stall}, 1);
        chk("flush_bus_idle", {31'd0, u.bus_req}, 0);
        step; u.if_addr = 32'h0040_0020; mem_wait = 0; t0 = cyc;
        sb.push_back('{1'b0, 32'h2402_0001});
        @(negedge clk); @(negedge clk);
        chk("refetch_addr", u.bus_addr, 32'h0040_0020);
        wait_if(5);
        step; u.if_req = 0;
        chk("refetch_latency", t_if - t0, 2);
`ifdef UMA_TIMEOUT_EN
        // Memory never answers: timeout after 8 BUSY cycles
        u.dm_req = 1; u.dm_addr = 32'h1001_0004; mem_wait = 100000; t0 = cyc;
        sb.push_back('{1'b1, 32'h0});
        repeat (9) @(negedge clk);
        chk("to_err_early", {31'd0, u.bus_err}, 0);
        chk("to_bus_req", {31'd0, u.bus_req}, 1);
        wait_dm(3);
        chk("to_latency", t_dm - t0, 9);
        chk("to_err_set", {31'd0, u.bus_err}, 1);
        step; u.dm_req = 0; mem_wait = 0;
        repeat (3) @(negedge clk);
        chk("to_err_sticky", {31'd0, u.bus_err}, 1);
        step; rst = 1;
        step; rst = 0;
        @(negedge clk);
        chk("to_err_cleared", {31'd0, u.bus_err}, 0);
`else
        // Without the timeout a slow memory is simply waited for
        u.dm_req = 1; u.dm_addr = 32'h1001_0000; mem_wait = 20;
        sb.push_back('{1'b1, 32'hCAFE_F00D});
        wait_dm(40);
        chk("slow_no_err", {31'd0, u.bus_err}, 0);
        step; u.dm_req = 0; mem_wait = 0;
`endif
        // Reset in the middle of an access
        u.if_req = 1; u.if_addr = 32'h0040_0000; mem_wait = 100;
        step; rst = 1;
        @(negedge clk);
        chk("mid_busy", {31'd0, u.bus_req}, 1);
        step; rst = 0; u.if_req = 0;
        @(negedge clk);
        chk("mid_rst_bus_req", {31'd0, u.bus_req}, 0);
        chk("mid_rst_if_rdata", u.if_rdata, 0);
        mem_wait = 0;
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
